// File: rtl/varredura_display.sv
// rtl/varredura_display.sv - multiplexed 4-digit hex display scanner with frame-synchronous value update
module varredura_display #(
    parameter int DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        carga,
    input  logic [15:0] valor,
    input  logic        apagar_zeros,
    output logic [3:0]  digito,
    output logic        apaga,
    output logic [3:0]  anodo,
    output logic        atualizado
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;
    logic [1:0]    indice;
    logic [15:0]   exibido;
    logic [15:0]   pendente;
    logic          pend_ok;
    logic          zeros_en;
    logic          tick;
    logic          frame_end;
    logic [3:0]    lz;

    assign tick      = (cnt == CW'(DIV - 1));
    assign frame_end = tick && (indice == 2'd3);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            indice     <= 2'd0;
            exibido    <= 16'h0000;
            pendente   <= 16'h0000;
            pend_ok    <= 1'b0;
            zeros_en   <= 1'b0;
            atualizado <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                indice <= indice + 2'd1;
            end
            // The transfer reads the old shadow value, so a load on the
            // frame-end cycle lands in pendente for the following frame.
            atualizado <= frame_end && pend_ok;
            if (frame_end && pend_ok) begin
                exibido <= pendente;
            end
            if (carga) begin
                pendente <= valor;
                pend_ok  <= 1'b1;
            end else if (frame_end) begin
                pend_ok  <= 1'b0;
            end
            zeros_en <= apagar_zeros;
        end
    end

    // lz[k]: nibbles k..3 of the shown value are all zero
    always_comb begin
        lz[0] = 1'b0;
        lz[3] = (exibido[15:12] == 4'h0);
        lz[2] = lz[3] && (exibido[11:8] == 4'h0);
        lz[1] = lz[2] && (exibido[7:4] == 4'h0);
    end

    always_comb begin
        anodo  = 4'b0001 << indice;
        digito = exibido[{indice, 2'b00} +: 4];
        apaga  = zeros_en && (indice != 2'd0) && lz[indice];
    end

endmodule

// File: tb/tb_varredura_display.sv
// tb/tb_varredura_display.sv - randomized and directed bench for varredura_display against a frame-level model
module tb_varredura_display;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        carga = 1'b0;
    logic [15:0] valor = 16'h0000;
    logic        apagar_zeros = 1'b0;
    logic [3:0]  digito;
    logic        apaga;
    logic [3:0]  anodo;
    logic        atualizado;

    int vectors = 0;
    int errors  = 0;

    // Model: time since reset in clock edges, plus shown/pending values.
    int          m_cyc   = 0;
    logic [15:0] m_exib  = 16'h0000;
    logic [15:0] m_pend  = 16'h0000;
    logic        m_pok   = 1'b0;
    logic        m_zeros = 1'b0;
    logic        m_upd   = 1'b0;

    varredura_display #(.DIV(DIV)) dut (
        .clock        (clock),
        .reset        (reset),
        .carga        (carga),
        .valor        (valor),
        .apagar_zeros (apagar_zeros),
        .digito       (digito),
        .apaga        (apaga),
        .anodo        (anodo),
        .atualizado   (atualizado)
    );

    always #5 clock = ~clock;

    function automatic int sig_digits(input logic [15:0] v);
        int n = 1;
        for (int k = 1; k < 4; k++) begin
            if (v[4*k +: 4] != 4'h0) n = k + 1;
        end
        return n;
    endfunction

    function automatic logic [9:0] expected();
        int         idx;
        logic [3:0] an;
        logic [3:0] dg;
        logic       ap;
        idx = (m_cyc / DIV) % 4;
        an  = 4'(1 << idx);
        dg  = m_exib[4*idx +: 4];
        ap  = m_zeros && (idx >= sig_digits(m_exib));
        return {an, dg, ap, m_upd};
    endfunction

    function automatic logic [9:0] observed();
        return {anodo, digito, apaga, atualizado};
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_exib = 16'h0000; m_pend = 16'h0000;
        m_pok = 1'b0; m_zeros = 1'b0; m_upd = 1'b0;
    endtask

    task automatic step();
        logic fe;
        @(posedge clock);
        fe    = (m_cyc % FRAME) == FRAME - 1;
        m_upd = fe && m_pok;
        if (fe && m_pok) begin
            m_exib = m_pend;
            m_pok  = 1'b0;
        end
        if (carga) begin
            m_pend = valor;
            m_pok  = 1'b1;
        end
        m_zeros = apagar_zeros;
        m_cyc++;
        @(negedge clock);
    endtask

    task automatic advance_to(input int phase);
        for (int i = 0; i < 2 * FRAME && (m_cyc % FRAME) != phase; i++) step();
    endtask

    task automatic hard_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1;
        vectors++;
        if (observed() !== 10'b0001_0000_0_0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", observed(), 10'b0001_0000_0_0);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < DIV; i++) begin
            step();
            vectors++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL reset_count cyc=%0d got=%b exp=%b", m_cyc, observed(), expected());
            end
        end
        vectors++;
        if (anodo !== 4'b0010) begin
            errors++;
            $display("FAIL first_tick anodo=%b exp=0010", anodo);
        end
    endtask

    task automatic test_load();
        int pulses = 0;
        logic [15:0] v = 16'h12AB;
        advance_to(5);
        carga = 1'b1; valor = v;
        step();
        carga = 1'b0;
        pulses += int'(atualizado);
        for (int i = 0; i < FRAME && (m_cyc % FRAME) != 0; i++) begin
            step();
            pulses += int'(atualizado);
            vectors++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL load_wait cyc=%0d got=%b exp=%b", m_cyc, observed(), expected());
            end
            if ((m_cyc % FRAME) != 0 && digito !== 4'h0) begin
                errors++;
                $display("FAIL load_early digito=%h exp=0", digito);
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            if (i != 0) begin
                step();
                pulses += int'(atualizado);
            end
            vectors++;
            if ({anodo, digito} !== {4'(1 << (i / DIV)), v[4*(i/DIV) +: 4]}) begin
                errors++;
                $display("FAIL load_scan i=%0d got=%b_%h exp=%b_%h", i, anodo, digito,
                         4'(1 << (i / DIV)), v[4*(i/DIV) +: 4]);
            end
        end
        vectors++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL load_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_blank();
        logic [15:0] vals [2] = '{16'h0030, 16'h0000};
        logic [3:0]  exp_blank [2] = '{4'b1100, 4'b1110};
        apagar_zeros = 1'b1;
        for (int t = 0; t < 2; t++) begin
            advance_to(2);
            carga = 1'b1; valor = vals[t];
            step();
            carga = 1'b0;
            advance_to(0);
            for (int i = 0; i < FRAME; i++) begin
                vectors++;
                if (observed() !== expected() || apaga !== exp_blank[t][i / DIV]
                    || digito !== vals[t][4*(i/DIV) +: 4]) begin
                    errors++;
                    $display("FAIL blank v=%h i=%0d got=%b exp=%b apaga_req=%b", vals[t], i,
                             observed(), expected(), exp_blank[t][i / DIV]);
                end
                step();
            end
        end
        apagar_zeros = 1'b0;
        step();
        vectors++;
        if (apaga !== 1'b0) begin
            errors++;
            $display("FAIL blank_off apaga=%b exp=0", apaga);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        advance_to(2);
        carga = 1'b1; valor = 16'h1111;
        step();
        carga = 1'b0;
        pulses += int'(atualizado);
        advance_to(9);
        carga = 1'b1; valor = 16'h2222;
        step();
        carga = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            pulses += int'(atualizado);
            vectors++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", m_cyc, observed(), expected());
            end
            if (i >= FRAME && digito !== 4'h2) begin
                errors++;
                $display("FAIL b2b_value digito=%h exp=2", digito);
            end
            step();
        end
        vectors++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL b2b_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_frame_end_load();
        int pulses = 0;
        advance_to(4);
        carga = 1'b1; valor = 16'h4444;
        step();
        carga = 1'b0;
        advance_to(FRAME - 1);
        carga = 1'b1; valor = 16'h5555;
        step();
        carga = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            pulses += int'(atualizado);
            vectors++;
            if (observed() !== expected() || digito !== ((i < FRAME) ? 4'h4 : 4'h5)) begin
                errors++;
                $display("FAIL frame_end_load i=%0d got=%b exp=%b", i, observed(), expected());
            end
            step();
        end
        vectors++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL frame_end_pulses got=%0d exp=2", pulses);
        end
    endtask

    task automatic test_async_reset();
        advance_to(3);
        carga = 1'b1; valor = 16'h9876;
        step();
        carga = 1'b0;
        advance_to(7);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (observed() !== 10'b0001_0000_0_0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", observed(), 10'b0001_0000_0_0);
        end
        model_reset();
        repeat (2) @(negedge clock);
        vectors++;
        if (observed() !== 10'b0001_0000_0_0) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=%b", observed(), 10'b0001_0000_0_0);
        end
        reset = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            vectors++;
            if (observed() !== expected() || digito !== 4'h0 || atualizado !== 1'b0) begin
                errors++;
                $display("FAIL discard cyc=%0d got=%b exp=%b", m_cyc, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [15:0] mask;
        for (int i = 0; i < 600; i++) begin
            carga = ($urandom_range(0, 7) == 0);
            v     = 16'($urandom);
            mask  = 16'hFFFF >> (4 * $urandom_range(0, 4));
            valor = v & mask;
            if ($urandom_range(0, 31) == 0) apagar_zeros = ~apagar_zeros;
            step();
            vectors++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", m_cyc, observed(), expected());
            end
        end
        carga = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_blank();
        test_back_to_back();
        test_frame_end_load();
        test_async_reset();
        test_random();
        hard_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/varredura_display.md
VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, giving the clock cycles each digit stays selected; legal values are DIV >= 2.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port carga, input, 1 bit: load strobe; valor is sampled on a rising edge where carga=1.
REQ-005 The block SHALL have port valor, input, 16 bits: four hex digits; valor[3:0] is digit 0 (least significant).
REQ-006 The block SHALL have port apagar_zeros, input, 1 bit: 1 enables leading-zero blanking.
REQ-007 The block SHALL have port digito, output, 4 bits: nibble of the selected digit, feeding the 7-segment decoder input.
REQ-008 The block SHALL have port apaga, output, 1 bit: 1 blanks the selected digit, feeding the decoder's blank/reset input.
REQ-009 The block SHALL have port anodo, output, 4 bits: one-hot, active-high digit select; anodo[k] selects digit k.
REQ-010 The block SHALL have port atualizado, output, 1 bit: one-cycle pulse marking a new value becoming visible.

Function
REQ-011 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; the cycle with cnt=DIV-1 is the "tick".
REQ-012 Digit index indice (2 bits) SHALL advance 0->1->2->3->0 on each tick and otherwise hold.
REQ-013 The cycle with a tick and indice=3 is the "frame end".
REQ-014 anodo SHALL be one-hot of indice at all times outside reset; 4'b0000 and multi-hot values are forbidden.
REQ-015 digito SHALL equal nibble indice of the display register exibido.
REQ-016 digito, apaga and anodo SHALL be functions of registered state only, with no combinational path from any input.
REQ-017 carga=1 SHALL copy valor into shadow register pendente and set flag pend_ok; carga while pend_ok=1 SHALL overwrite pendente (last load wins).
REQ-018 At frame end with pend_ok=1, exibido SHALL take pendente and pend_ok SHALL clear, so a value is never shown with mixed digits in one frame.
REQ-019 atualizado SHALL be 1 during the single cycle after a transfer per REQ-018 and 0 otherwise.
REQ-020 carga=1 on a frame-end cycle SHALL transfer the previous pendente, then store the new valor with pend_ok=1; the new value is transferred at the next frame end.
REQ-021 carga=1 on a frame-end cycle with pend_ok=0 SHALL NOT transfer; the value is transferred at the next frame end.
REQ-022 With apagar_zeros=1, apaga SHALL be 1 for digit k (k in 1..3) when nibbles k..3 of exibido are all zero.
REQ-023 Digit 0 SHALL never be blanked.
REQ-024 With apagar_zeros=0, apaga SHALL be 0.
REQ-025 apagar_zeros SHALL act on the current digit without waiting for a frame end.

Reset
REQ-026 While reset=0, and immediately on assertion without waiting for a clock edge, the block SHALL hold: cnt=0, indice=0, exibido=16'h0000, pendente=16'h0000, pend_ok=0.
REQ-027 While reset=0, the outputs SHALL be anodo=4'b0001, digito=4'h0, apaga=0, atualizado=0.
REQ-028 After reset=1, counting SHALL restart from cnt=0 on the first rising edge.
REQ-029 A pending load SHALL be discarded by reset.

Verification (DIV=4)
REQ-030 Reset -> anodo=0001, digito=0, apaga=0, atualizado=0; first tick after 4 edges gives anodo=0010.
REQ-031 Pulse carga, valor=16'h12AB, mid-frame -> display unchanged until frame end; atualizado pulses once; then digito B,A,2,1 for 4 cycles each with anodo 0001,0010,0100,1000.
REQ-032 apagar_zeros=1, value 16'h0030 -> apaga=1 on digits 3,2; digits 1,0 show 3,0. Value 16'h0000 -> only digit 0 unblanked, showing 0.
REQ-033 Two carga pulses (16'h1111, then 16'h2222) in one frame -> only 2222 displayed; exactly one atualizado pulse.
REQ-034 carga 16'h5555 on a frame-end cycle with 16'h4444 pending -> 4444 shown next frame, 5555 the frame after; two atualizado pulses.
REQ-035 Reset=0 asynchronously mid-frame with a load pending -> outputs return to reset values at once; the pending value is never displayed.
